// File: rtl/btn_evt_pkg.sv
// Shared event codes, per-button FSM states and sizing helpers for the
// button event controller.
package btn_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_LONG    = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;
    localparam logic [1:0] EVT_RELEASE = 2'd3;

    // One pending bit per event kind; bit index equals event code.
    localparam int N_EVT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Valid/ready event port carrying the button index and event code.
interface button_event_ctrl_if #(
    parameter int BTN_W = 2
) ();

    logic             evt_valid;
    logic             evt_ready;
    logic [BTN_W-1:0] evt_btn;
    logic [1:0]       evt_code;

    modport master (output evt_valid, output evt_btn, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_btn, input evt_code, output evt_ready);

endinterface

// File: rtl/btn_press_fsm.sv
// Per-button edge detector and press/long/repeat/release FSM producing
// one-cycle raise pulses, one bit per event code.
module btn_press_fsm
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = 24,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_db,
    output logic [N_EVT-1:0] raise_s
);

    localparam int CNT_W = idx_width(max2(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             prev_r;
    logic             rise_s;
    logic             fall_s;
    btn_state_e       state_r;
    btn_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    // Previous level sample; cleared by reset so a held button re-presses.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= btn_db;
        end
    end

    assign rise_s = btn_db & ~prev_r;
    assign fall_s = ~btn_db & prev_r;

    // State and hold counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state and raise pulses; a release always wins over long/repeat.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        raise_s = {N_EVT{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_s            = ST_PRESSED;
                    cnt_s              = CNT_ZERO;
                    raise_s[EVT_PRESS] = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (fall_s) begin
                    state_s              = ST_IDLE;
                    cnt_s                = CNT_ZERO;
                    raise_s[EVT_RELEASE] = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    state_s           = ST_HELD;
                    cnt_s             = CNT_ZERO;
                    raise_s[EVT_LONG] = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (fall_s) begin
                    state_s              = ST_IDLE;
                    cnt_s                = CNT_ZERO;
                    raise_s[EVT_RELEASE] = 1'b1;
                end else if (cnt_r == REPEAT_LAST) begin
                    cnt_s               = CNT_ZERO;
                    raise_s[EVT_REPEAT] = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Merges per-button UI events into one round-robin valid/ready stream and
// flags events lost because their pending slot was still occupied.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = 24,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_BTN-1:0]           btn_db,
    button_event_ctrl_if.master        evt,
    output logic                       ovf,
    input  logic                       clr_ovf
);

    localparam int BTN_W = idx_width(N_BTN);
    localparam logic [BTN_W-1:0] BTN_ZERO = BTN_W'(0);
    localparam logic [BTN_W-1:0] BTN_ONE  = BTN_W'(1);
    localparam logic [BTN_W-1:0] BTN_LAST = BTN_W'(N_BTN - 1);

    logic [N_BTN-1:0][N_EVT-1:0] raise_s;
    logic [N_BTN-1:0][N_EVT-1:0] pending_r;
    logic [N_BTN-1:0][N_EVT-1:0] pending_s;
    logic [N_BTN-1:0][N_EVT-1:0] drain_s;
    logic                        drop_s;
    logic                        load_s;
    logic                        found_s;
    logic [BTN_W-1:0]            grant_s;
    logic [1:0]                  code_s;
    logic [BTN_W-1:0]            rr_next_s;
    logic                        valid_r;
    logic [BTN_W-1:0]            btn_r;
    logic [1:0]                  code_r;
    logic [BTN_W-1:0]            rr_r;
    logic                        ovf_r;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_press_fsm #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_fsm (
            .clk     (clk),
            .reset   (reset),
            .btn_db  (btn_db[g]),
            .raise_s (raise_s[g])
        );
    end

    assign load_s = ~valid_r | evt.evt_ready;

    // Round-robin search from rr_r; the lowest pending bit of the winner is its code.
    always_comb begin
        int               idx_v;
        logic [BTN_W-1:0] idx_b;
        idx_v   = 0;
        idx_b   = BTN_ZERO;
        found_s = 1'b0;
        grant_s = BTN_ZERO;
        code_s  = EVT_PRESS;
        for (int i = 0; i < N_BTN; i++) begin
            idx_v = (int'(rr_r) + i) % N_BTN;
            idx_b = BTN_W'(idx_v);
            if (!found_s && (pending_r[idx_b] != {N_EVT{1'b0}})) begin
                found_s = 1'b1;
                grant_s = idx_b;
                for (int e = N_EVT - 1; e >= 0; e--) begin
                    code_s = pending_r[idx_b][2'(e)] ? 2'(e) : code_s;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    // Drain the granted bit; a raise on a still-occupied, undrained slot is a drop.
    always_comb begin
        drain_s = {(N_BTN * N_EVT){1'b0}};
        if (load_s && found_s) begin
            drain_s[grant_s][code_s] = 1'b1;
        end else begin
            drain_s = {(N_BTN * N_EVT){1'b0}};
        end
        pending_s = (pending_r & ~drain_s) | raise_s;
        drop_s    = |(raise_s & pending_r & ~drain_s);
        rr_next_s = (grant_s == BTN_LAST) ? BTN_ZERO : (grant_s + BTN_ONE);
    end

    // Pending event bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {(N_BTN * N_EVT){1'b0}};
        end else begin
            pending_r <= pending_s;
        end
    end

    // Sticky overflow; a drop in the same cycle overrides a clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (clr_ovf) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Output event register and round-robin pointer; held while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            btn_r   <= BTN_ZERO;
            code_r  <= EVT_PRESS;
            rr_r    <= BTN_ZERO;
        end else if (load_s) begin
            valid_r <= found_s;
            if (found_s) begin
                btn_r  <= grant_s;
                code_r <= code_s;
                rr_r   <= rr_next_s;
            end else begin
                btn_r  <= btn_r;
                code_r <= code_r;
                rr_r   <= rr_r;
            end
        end else begin
            valid_r <= valid_r;
            btn_r   <= btn_r;
            code_r  <= code_r;
            rr_r    <= rr_r;
        end
    end

    assign evt.evt_valid = valid_r;
    assign evt.evt_btn   = btn_r;
    assign evt.evt_code  = code_r;
    assign ovf           = ovf_r;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed table, multi-cycle corner sequences
// and randomized traffic, all checked against a hold-time based event model.
module tb_button_event_ctrl;
    import btn_evt_pkg::*;

    localparam int N_BTN = 4;
    localparam int LONG  = 24;
    localparam int REP   = 8;
    localparam int BTN_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_BTN-1:0] btn_db;
    logic             ready;
    logic             clr_ovf;
    logic             ovf;

    button_event_ctrl_if #(.BTN_W(BTN_W)) evt_if ();
    assign evt_if.evt_ready = ready;

    button_event_ctrl #(
        .N_BTN         (N_BTN),
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_db  (btn_db),
        .evt     (evt_if),
        .ovf     (ovf),
        .clr_ovf (clr_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: hold time per button, pending slots, output and pointer.
    int m_h[N_BTN];
    bit m_prev[N_BTN];
    bit m_pend[N_BTN][4];
    int m_rr;
    bit m_valid;
    int m_btn;
    int m_code;
    bit m_ovf;

    typedef struct packed {
        logic [3:0] btn;
        logic       vld;
        logic [1:0] b;
        logic [1:0] code;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < N_BTN; b++) begin
            m_h[b]    = 0;
            m_prev[b] = 1'b0;
            for (int e = 0; e < 4; e++) m_pend[b][e] = 1'b0;
        end
        m_rr = 0; m_valid = 1'b0; m_btn = 0; m_code = 0; m_ovf = 1'b0;
    endtask

    task automatic model_step();
        bit got;
        bit drop;
        int ev;
        int bb;
        if (reset) begin
            model_reset();
            return;
        end
        if (!m_valid || ready) begin
            got = 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                bb = (m_rr + i) % N_BTN;
                for (int e = 0; e < 4; e++) begin
                    if (!got && m_pend[bb][e]) begin
                        got = 1'b1; m_btn = bb; m_code = e;
                        m_pend[bb][e] = 1'b0;
                        m_rr = (bb + 1) % N_BTN;
                    end
                end
            end
            m_valid = got;
        end
        drop = 1'b0;
        for (int b = 0; b < N_BTN; b++) begin
            bit lvl;
            lvl = btn_db[2'(b)];
            ev  = -1;
            if (lvl && !m_prev[b]) begin
                ev = 0; m_h[b] = 0;
            end else if (!lvl && m_prev[b]) begin
                ev = 3;
            end else if (lvl) begin
                m_h[b]++;
                if (m_h[b] == LONG) ev = 1;
                else if (m_h[b] > LONG && ((m_h[b] - LONG) % REP) == 0) ev = 2;
            end
            if (ev >= 0) begin
                if (m_pend[b][ev]) drop = 1'b1;
                m_pend[b][ev] = 1'b1;
            end
            m_prev[b] = lvl;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("model_valid", int'(evt_if.evt_valid), int'(m_valid));
        if (m_valid) begin
            check("model_btn", int'(evt_if.evt_btn), m_btn);
            check("model_code", int'(evt_if.evt_code), m_code);
        end
        check("model_ovf", int'(ovf), int'(m_ovf));
    endtask

    task automatic expect_evt(input string name, input bit v, input int b, input int c);
        check({name, "_valid"}, int'(evt_if.evt_valid), int'(v));
        if (v) begin
            check({name, "_btn"}, int'(evt_if.evt_btn), b);
            check({name, "_code"}, int'(evt_if.evt_code), c);
        end
    endtask

    task automatic add(input logic [3:0] btn, input logic vld, input int b, input int c);
        vec_t r;
        r.btn = btn; r.vld = vld; r.b = 2'(b); r.code = 2'(c);
        tbl.push_back(r);
    endtask

    initial begin
        reset = 1'b1; btn_db = 4'b0000; ready = 1'b1; clr_ovf = 1'b0;
        model_reset();
        tick(); tick();
        check("rst_valid", int'(evt_if.evt_valid), 0);
        check("rst_btn", int'(evt_if.evt_btn), 0);
        check("rst_code", int'(evt_if.evt_code), 0);
        check("rst_ovf", int'(ovf), 0);
        reset = 1'b0;

        // All four pressed together, then two together with pointer back at 0,
        // then a short single press.
        add(4'b0000, 1'b0, 0, 0);
        add(4'b1111, 1'b0, 0, 0);
        add(4'b1111, 1'b1, 0, 0);
        add(4'b1111, 1'b1, 1, 0);
        add(4'b1111, 1'b1, 2, 0);
        add(4'b1111, 1'b1, 3, 0);
        add(4'b1111, 1'b0, 0, 0);
        add(4'b0000, 1'b0, 0, 0);
        add(4'b0000, 1'b1, 0, 3);
        add(4'b0000, 1'b1, 1, 3);
        add(4'b0000, 1'b1, 2, 3);
        add(4'b0000, 1'b1, 3, 3);
        add(4'b0000, 1'b0, 0, 0);
        add(4'b0101, 1'b0, 0, 0);
        add(4'b0101, 1'b1, 0, 0);
        add(4'b0101, 1'b1, 2, 0);
        add(4'b0101, 1'b0, 0, 0);
        add(4'b0000, 1'b0, 0, 0);
        add(4'b0000, 1'b1, 0, 3);
        add(4'b0000, 1'b1, 2, 3);
        add(4'b0000, 1'b0, 0, 0);
        add(4'b0001, 1'b0, 0, 0);
        add(4'b0001, 1'b1, 0, 0);
        add(4'b0001, 1'b0, 0, 0);
        add(4'b0001, 1'b0, 0, 0);
        add(4'b0001, 1'b0, 0, 0);
        add(4'b0000, 1'b0, 0, 0);
        add(4'b0000, 1'b1, 0, 3);
        add(4'b0000, 1'b0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            btn_db = tbl[i].btn;
            tick();
            expect_evt("tbl", tbl[i].vld, int'(tbl[i].b), int'(tbl[i].code));
        end

        // Long hold: LONG after 24 cycles, REPEAT every 8 after that.
        btn_db = 4'b0001; tick();
        for (int j = 1; j <= 41; j++) begin
            tick();
            if (j == 1)  expect_evt("hold_press", 1'b1, 0, int'(EVT_PRESS));
            if (j == 24) expect_evt("hold_nolong", 1'b0, 0, 0);
            if (j == 25) expect_evt("hold_long", 1'b1, 0, int'(EVT_LONG));
            if (j == 33) expect_evt("hold_rep1", 1'b1, 0, int'(EVT_REPEAT));
            if (j == 41) expect_evt("hold_rep2", 1'b1, 0, int'(EVT_REPEAT));
        end
        btn_db = 4'b0000; tick(); tick();
        expect_evt("hold_release", 1'b1, 0, int'(EVT_RELEASE));
        tick();

        // Release on the very cycle LONG would fire.
        btn_db = 4'b1000; tick();
        for (int j = 1; j <= 23; j++) tick();
        btn_db = 4'b0000; tick(); tick();
        expect_evt("edge_release", 1'b1, 3, int'(EVT_RELEASE));
        tick();
        expect_evt("edge_nolong", 1'b0, 0, 0);

        // Stalled consumer: output stays on PRESS, second REPEAT overflows.
        ready = 1'b0; btn_db = 4'b0010; tick();
        for (int j = 1; j <= 100; j++) begin
            tick();
            expect_evt("stall", 1'b1, 1, int'(EVT_PRESS));
            if (j == 39) check("stall_ovf_pre", int'(ovf), 0);
            if (j == 40) check("stall_ovf_set", int'(ovf), 1);
        end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("stall_ovf_clr", int'(ovf), 0);
        ready = 1'b1; repeat (4) tick();
        btn_db = 4'b0000; repeat (6) tick();

        // Reset while a button is in the repeating phase.
        btn_db = 4'b0100; tick();
        repeat (30) tick();
        reset = 1'b1; tick();
        check("mid_rst_valid", int'(evt_if.evt_valid), 0);
        check("mid_rst_btn", int'(evt_if.evt_btn), 0);
        check("mid_rst_code", int'(evt_if.evt_code), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        reset = 1'b0; tick(); tick();
        expect_evt("rst_repress", 1'b1, 2, int'(EVT_PRESS));
        for (int j = 0; j < 12; j++) begin
            tick();
            expect_evt("rst_no_stale", 1'b0, 0, 0);
        end
        btn_db = 4'b0000; repeat (4) tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N_BTN; b++) begin
                if ($urandom_range(0, 39) == 0) btn_db[2'(b)] = ~btn_db[2'(b)];
            end
            if (c >= 2000 && c < 2150) ready = 1'b0;
            else ready = ($urandom_range(0, 9) < 7);
            clr_ovf = ($urandom_range(0, 99) == 0);
            reset   = ($urandom_range(0, 1499) == 0);
            tick();
        end
        reset = 1'b0; clr_ovf = 1'b0; ready = 1'b1; btn_db = 4'b0000;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
